// File: rtl/keypad_time_entry.sv
// Keypad scanner and MM:SS time entry.
// Drives one keypad column low at a time, samples the synchronised rows at
// the end of each column window, debounces whole-scan results and turns
// accepted keys into a right-aligned 4-digit BCD entry. Enter (D) validates
// the seconds tens digit and presents the time to the timer FSM.
module keypad_time_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_pulse,
  output logic [3:0]  key_code,
  output logic [15:0] entry_bcd,
  output logic [2:0]  digit_count,
  output logic        time_valid,
  output logic [15:0] time_bcd,
  output logic        entry_err
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1) + 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  // Fixed keypad legend: row r, column c -> key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta_reg, row_sync_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       col_n_reg;
  logic [1:0]       hits_reg;      // keys seen so far this scan, saturating at 2 (multi)
  logic [3:0]       code_acc_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]       cand_reg, cand_next;
  logic             key_pulse_reg;
  logic [3:0]       key_code_reg, key_code_next;
  logic [15:0]      entry_reg, entry_next, time_reg, time_next;
  logic [2:0]       count_reg, count_next;
  logic             time_valid_reg, time_valid_next, entry_err_reg, entry_err_next;

  logic [3:0]  row_code [4];
  logic        sample_tick, scan_done, scan_single, accept;
  logic [1:0]  col_hits, total_hits;
  logic [2:0]  hit_sum;
  logic [3:0]  col_code, scan_code, accept_code;

  // Code each row would produce in the column currently driven.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row_code
      assign row_code[gi] = key_map(2'(gi), col_idx_reg);
    end
  endgenerate

  assign sample_tick = (div_reg == DIV_W'(SCAN_DIV - 1));
  assign scan_done   = sample_tick && (col_idx_reg == 2'd3);
  assign cnt_inc     = cnt_reg + CNT_W'(1);

  // Count pressed rows in this column and merge with the scan-so-far result.
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_reg[r]) begin
        col_hits = (col_hits == 2'd2) ? 2'd2 : col_hits + 2'd1;
        col_code = row_code[r];
      end
    end
    hit_sum     = {1'b0, hits_reg} + {1'b0, col_hits};
    total_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code   = (hits_reg == 2'd1) ? code_acc_reg : col_code;
    scan_single = (total_hits == 2'd1);
  end

  // Synchroniser, column scanner and per-scan accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
      div_reg      <= '0;
      col_idx_reg  <= 2'd0;
      col_n_reg    <= 4'b1110;
      hits_reg     <= 2'd0;
      code_acc_reg <= 4'h0;
    end else begin
      row_meta_reg <= row_n;
      row_sync_reg <= row_meta_reg;
      if (sample_tick) begin
        div_reg     <= '0;
        col_idx_reg <= col_idx_reg + 2'd1;
        col_n_reg   <= ~(4'b0001 << (col_idx_reg + 2'd1));
        if (scan_done) begin
          hits_reg     <= 2'd0;
          code_acc_reg <= 4'h0;
        end else begin
          hits_reg     <= total_hits;
          code_acc_reg <= scan_code;
        end
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  // Debounce FSM next state, evaluated once per completed scan; MULTI counts as NONE.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    cand_next   = cand_reg;
    accept      = 1'b0;
    accept_code = cand_reg;
    if (scan_done) begin
      case (state_reg)
        IDLE: if (scan_single) begin
          cand_next   = scan_code;
          cnt_next    = CNT_W'(1);
          accept_code = scan_code;
          if (DEBOUNCE_SCANS <= 1) begin
            accept     = 1'b1;
            state_next = HELD;
          end else begin
            state_next = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!scan_single) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (scan_code == cand_reg) begin
            if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
              accept     = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cand_next = scan_code;
            cnt_next  = CNT_W'(1);
          end
        end
        HELD: if (!scan_single) begin
          cnt_next   = CNT_W'(1);
          state_next = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE;
        end
        default: begin
          if (scan_single) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt_inc >= CNT_W'(DEBOUNCE_SCANS)) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      endcase
    end
  end

  // Entry editing and Enter validation for an accepted key.
  always_comb begin
    entry_next      = entry_reg;
    count_next      = count_reg;
    time_next       = time_reg;
    time_valid_next = 1'b0;
    entry_err_next  = 1'b0;
    key_code_next   = key_code_reg;
    if (accept) begin
      key_code_next = accept_code;
      case (accept_code)
        4'hA: begin
          entry_next = 16'h0000;
          count_next = 3'd0;
        end
        4'hB: begin
          entry_next = entry_reg >> 4;
          count_next = (count_reg == 3'd0) ? 3'd0 : count_reg - 3'd1;
        end
        4'hD: begin
          if ((count_reg != 3'd0) && (entry_reg[7:4] <= 4'd5)) begin
            time_next       = entry_reg;
            time_valid_next = 1'b1;
            entry_next      = 16'h0000;
            count_next      = 3'd0;
          end else begin
            entry_err_next = 1'b1;
          end
        end
        default: if ((accept_code <= 4'd9) && (count_reg < 3'd4)) begin
          entry_next = {entry_reg[11:0], accept_code};
          count_next = count_reg + 3'd1;
        end
      endcase
    end
  end

  // FSM and entry state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cand_reg       <= 4'h0;
      key_pulse_reg  <= 1'b0;
      key_code_reg   <= 4'h0;
      entry_reg      <= 16'h0000;
      count_reg      <= 3'd0;
      time_reg       <= 16'h0000;
      time_valid_reg <= 1'b0;
      entry_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cand_reg       <= cand_next;
      key_pulse_reg  <= accept;
      key_code_reg   <= key_code_next;
      entry_reg      <= entry_next;
      count_reg      <= count_next;
      time_reg       <= time_next;
      time_valid_reg <= time_valid_next;
      entry_err_reg  <= entry_err_next;
    end
  end

  assign col_n       = col_n_reg;
  assign key_pulse   = key_pulse_reg;
  assign key_code    = key_code_reg;
  assign entry_bcd   = entry_reg;
  assign digit_count = count_reg;
  assign time_valid  = time_valid_reg;
  assign time_bcd    = time_reg;
  assign entry_err   = entry_err_reg;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Bench for keypad_time_entry: a keypad model, a table of key presses with
// expected entry state, and hand-written bounce / multi-key / reset sequences.
module tb_keypad_time_entry;

  localparam int SD     = 4;
  localparam int DS     = 2;
  localparam int SCAN   = 4 * SD;

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        tv;
    logic [15:0] tbcd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_count;
  logic        time_valid;
  logic [15:0] time_bcd;
  logic        entry_err;

  logic [15:0] keys = 16'h0000;   // pressed switches, bit r*4+c
  vec_t        tbl[$];
  vec_t        exp_q[$];
  int          errors = 0, checks = 0;
  int          pulse_seen = 0, tv_seen = 0, err_seen = 0;
  int          exp_tv = 0, exp_err = 0;

  keypad_time_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
    .key_pulse(key_pulse), .key_code(key_code), .entry_bcd(entry_bcd),
    .digit_count(digit_count), .time_valid(time_valid), .time_bcd(time_bcd),
    .entry_err(entry_err)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a row is pulled low by any pressed key in a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  function automatic int key_idx(input logic [3:0] k);
    case (k)
      4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
      4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
      4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
      4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(input logic [3:0] k, input logic [15:0] e, input logic [2:0] n,
                     input logic tv, input logic [15:0] t, input logic er);
    vec_t v;
    v = '{key: k, entry: e, cnt: n, tv: tv, tbcd: t, err: er};
    tbl.push_back(v);
  endtask

  task automatic expect_key(input vec_t v);
    exp_q.push_back(v);
    exp_tv  += int'(v.tv);
    exp_err += int'(v.err);
  endtask

  // Hold a key for 6 scans, then release for 4 scans.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    keys = 16'(1) << key_idx(k);
    repeat (6 * SCAN) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(posedge clk);
  endtask

  // Scoreboard: every key_pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!reset) begin
      if (time_valid) tv_seen++;
      if (entry_err)  err_seen++;
      if (key_pulse) begin
        vec_t e;
        pulse_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse actual code=%h required no pulse", key_code);
        end else begin
          e = exp_q.pop_front();
          chk("key_code", 16'(key_code), 16'(e.key));
          chk("entry_bcd", entry_bcd, e.entry);
          chk("digit_count", 16'(digit_count), 16'(e.cnt));
          chk("time_valid", 16'(time_valid), 16'(e.tv));
          chk("time_bcd", time_bcd, e.tbcd);
          chk("entry_err", 16'(entry_err), 16'(e.err));
          $display("key %h: entry=%h count=%0d tv=%0b time=%h err=%0b",
                   key_code, entry_bcd, digit_count, time_valid, time_bcd, entry_err);
        end
      end
    end
  end

  initial begin : main
    int p0;
    int cyc;
    bit seen;
    vec_t v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col_n", 16'(col_n), 16'hE);
    chk("rst_entry", entry_bcd, 16'h0);
    chk("rst_time", time_bcd, 16'h0);
    chk("rst_strobes", 16'({key_pulse, time_valid, entry_err}), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table: key, entry, count, time_valid, time_bcd, entry_err
    add(4'h1, 16'h0001, 3'd1, 1'b0, 16'h0000, 1'b0);
    add(4'h2, 16'h0012, 3'd2, 1'b0, 16'h0000, 1'b0);
    add(4'h3, 16'h0123, 3'd3, 1'b0, 16'h0000, 1'b0);
    add(4'h0, 16'h1230, 3'd4, 1'b0, 16'h0000, 1'b0);
    add(4'hD, 16'h0000, 3'd0, 1'b1, 16'h1230, 1'b0);
    add(4'h9, 16'h0009, 3'd1, 1'b0, 16'h1230, 1'b0);
    add(4'h9, 16'h0099, 3'd2, 1'b0, 16'h1230, 1'b0);
    add(4'h9, 16'h0999, 3'd3, 1'b0, 16'h1230, 1'b0);
    add(4'h9, 16'h9999, 3'd4, 1'b0, 16'h1230, 1'b0);
    add(4'hD, 16'h9999, 3'd4, 1'b0, 16'h1230, 1'b1);
    add(4'hA, 16'h0000, 3'd0, 1'b0, 16'h1230, 1'b0);
    add(4'h4, 16'h0004, 3'd1, 1'b0, 16'h1230, 1'b0);
    add(4'h5, 16'h0045, 3'd2, 1'b0, 16'h1230, 1'b0);
    add(4'hB, 16'h0004, 3'd1, 1'b0, 16'h1230, 1'b0);
    add(4'hA, 16'h0000, 3'd0, 1'b0, 16'h1230, 1'b0);
    add(4'hD, 16'h0000, 3'd0, 1'b0, 16'h1230, 1'b1);
    add(4'h4, 16'h0004, 3'd1, 1'b0, 16'h1230, 1'b0);
    add(4'h5, 16'h0045, 3'd2, 1'b0, 16'h1230, 1'b0);
    add(4'hD, 16'h0000, 3'd0, 1'b1, 16'h0045, 1'b0);
    add(4'h1, 16'h0001, 3'd1, 1'b0, 16'h0045, 1'b0);
    add(4'h2, 16'h0012, 3'd2, 1'b0, 16'h0045, 1'b0);
    add(4'h3, 16'h0123, 3'd3, 1'b0, 16'h0045, 1'b0);
    add(4'h4, 16'h1234, 3'd4, 1'b0, 16'h0045, 1'b0);
    add(4'h5, 16'h1234, 3'd4, 1'b0, 16'h0045, 1'b0);
    add(4'hC, 16'h1234, 3'd4, 1'b0, 16'h0045, 1'b0);
    add(4'hE, 16'h1234, 3'd4, 1'b0, 16'h0045, 1'b0);
    add(4'hF, 16'h1234, 3'd4, 1'b0, 16'h0045, 1'b0);

    foreach (tbl[i]) begin
      expect_key(tbl[i]);
      press(tbl[i].key);
    end
    chk("code_held", 16'(key_code), 16'hF);

    // Keys 1 and 2 together: a multi-key scan never produces a key.
    p0 = pulse_seen;
    @(negedge clk);
    keys = (16'(1) << key_idx(4'h1)) | (16'(1) << key_idx(4'h2));
    repeat (6 * SCAN) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(posedge clk);
    chk("multi_pulses", 16'(pulse_seen - p0), 16'd0);

    // Key 5 bouncing every scan, then steady: exactly one pulse.
    p0 = pulse_seen;
    v = '{key: 4'h5, entry: 16'h1234, cnt: 3'd4, tv: 1'b0, tbcd: 16'h0045, err: 1'b0};
    expect_key(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      keys = (i % 2 == 0) ? (16'(1) << key_idx(4'h5)) : 16'h0000;
      repeat (SCAN) @(posedge clk);
    end
    @(negedge clk);
    keys = 16'(1) << key_idx(4'h5);
    repeat (6 * SCAN) @(posedge clk);
    @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(posedge clk);
    chk("bounce_pulses", 16'(pulse_seen - p0), 16'd1);

    // Key 7 held into HELD, then reset; it must re-debounce from scratch.
    v = '{key: 4'h7, entry: 16'h1234, cnt: 3'd4, tv: 1'b0, tbcd: 16'h0045, err: 1'b0};
    expect_key(v);
    @(negedge clk);
    keys = 16'(1) << key_idx(4'h7);
    repeat (4 * SCAN) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_col_n", 16'(col_n), 16'hE);
    chk("rst2_entry", entry_bcd, 16'h0);
    chk("rst2_count", 16'(digit_count), 16'd0);
    chk("rst2_time", time_bcd, 16'h0);
    chk("rst2_code", 16'(key_code), 16'h0);
    chk("rst2_strobes", 16'({key_pulse, time_valid, entry_err}), 16'h0);
    v = '{key: 4'h7, entry: 16'h0007, cnt: 3'd1, tv: 1'b0, tbcd: 16'h0000, err: 1'b0};
    expect_key(v);
    @(negedge clk);
    reset = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10 * SCAN) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == SD) chk("col_n_step", 16'(col_n), 16'hD);
      if (key_pulse) seen = 1'b1;
    end
    chk("repress_latency", 16'(cyc), 16'(2 * SCAN));
    @(negedge clk);
    keys = 16'h0000;
    repeat (4 * SCAN) @(posedge clk);

    // Totals
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    chk("tv_total", 16'(tv_seen), 16'(exp_tv));
    chk("err_total", 16'(err_seen), 16'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
